// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY datapath definitions used by both the transmit serializer
// and the receive byte deserializer.
//   mode_t          : word-size selector carried on the lane interface
//   BYTE_W          : width of one lane byte
//   words_per_mode  : index of the last byte of a word (N-1) for a mode
package pcie_phy_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    MODE_8    = 2'b00,
    MODE_16   = 2'b01,
    MODE_32   = 2'b10,
    MODE_RSVD = 2'b11
  } mode_t;

  // Last byte index of a word. The reserved mode never completes a word
  // (its bytes are dropped), so its value is irrelevant; 0 keeps it benign.
  function automatic logic [1:0] words_per_mode(input mode_t m);
    case (m)
      MODE_8:  return 2'd0;
      MODE_16: return 2'd1;
      MODE_32: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/byte_deserializer_if.sv
// Lane-side byte stream in, wide word out.
//   master : drives mode/align/in_valid/in, observes the word outputs
//   slave  : the deserializer itself
interface byte_deserializer_if #(
  parameter int BYTE_W = 8,
  parameter int OUT_W  = 32
);
  logic [1:0]        mode;
  logic              align;
  logic              in_valid;
  logic [BYTE_W-1:0] in;
  logic [OUT_W-1:0]  out;
  logic              out_valid;
  logic              busy;
  logic              mode_err;

  modport master (
    output mode, align, in_valid, in,
    input  out, out_valid, busy, mode_err
  );

  modport slave (
    input  mode, align, in_valid, in,
    output out, out_valid, busy, mode_err
  );
endinterface

// File: rtl/byte_deserializer.sv
// Receive-side byte deserializer: collects one lane byte per accepted cycle
// and reassembles 8/16/32-bit words, first byte in the low lane.
// Ports:
//   clk      : rising-edge clock
//   reset_L  : asynchronous active-low reset
//   bus      : byte_deserializer_if.slave
//              mode/align/in_valid/in in; out/out_valid/busy/mode_err out
module byte_deserializer #(
  parameter int BYTE_W = 8,
  parameter int OUT_W  = 32
) (
  input  logic                clk,
  input  logic                reset_L,
  byte_deserializer_if.slave  bus
);
  import pcie_phy_pkg::*;

  localparam int NUM_LANES = OUT_W / BYTE_W;

  // State
  logic [1:0]                        byte_idx, nxt_idx;
  mode_t                             mode_q, nxt_mode;
  logic [NUM_LANES-1:0][BYTE_W-1:0]  asm_q, nxt_asm, asm_w;
  logic [OUT_W-1:0]                  out_q, nxt_out;
  logic                              ov_q, nxt_ov;
  logic                              err_q, nxt_err;

  // Accept decode
  mode_t      mode_in;
  logic       mode_chg;
  logic       restart;
  logic [1:0] wr_idx;
  mode_t      eff_mode;

  assign mode_in  = mode_t'(bus.mode);
  assign mode_chg = (byte_idx != 2'd0) && (mode_in != mode_q);
  // A byte starts a fresh word either at a word boundary or when the mode
  // changed under a partial word (that partial is abandoned).
  assign restart  = (byte_idx == 2'd0) || (mode_in != mode_q);
  assign wr_idx   = restart ? 2'd0 : byte_idx;
  assign eff_mode = restart ? mode_in : mode_q;

  // Byte-lane write decoder: on a fresh word lane 0 takes the byte and the
  // upper lanes clear, which is what yields the zero-filled 8/16-bit words.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    localparam logic [1:0] LI = 2'(l);
    always_comb begin
      if (restart)
        asm_w[l] = (LI == 2'd0) ? bus.in : '0;
      else
        asm_w[l] = (LI == wr_idx) ? bus.in : asm_q[l];
    end
  end

  always_comb begin
    nxt_idx  = byte_idx;
    nxt_mode = mode_q;
    nxt_asm  = asm_q;
    nxt_out  = out_q;
    nxt_ov   = 1'b0;
    nxt_err  = 1'b0;
    if (bus.align) begin
      // Restart wins over everything, including a byte in the same cycle.
      nxt_idx = 2'd0;
      nxt_asm = '0;
    end else if (bus.in_valid) begin
      if (mode_in == MODE_RSVD) begin
        nxt_err = 1'b1;
        nxt_idx = 2'd0;
      end else begin
        nxt_err  = mode_chg;
        nxt_mode = eff_mode;
        nxt_asm  = asm_w;
        if (wr_idx == words_per_mode(eff_mode)) begin
          nxt_out = asm_w;
          nxt_ov  = 1'b1;
          nxt_idx = 2'd0;
        end else begin
          nxt_idx = wr_idx + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      byte_idx <= 2'd0;
      mode_q   <= MODE_8;
      asm_q    <= '0;
      out_q    <= '0;
      ov_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      byte_idx <= nxt_idx;
      mode_q   <= nxt_mode;
      asm_q    <= nxt_asm;
      out_q    <= nxt_out;
      ov_q     <= nxt_ov;
      err_q    <= nxt_err;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = ov_q;
  assign bus.mode_err  = err_q;
  assign bus.busy      = (byte_idx != 2'd0);

endmodule

// File: tb/tb_byte_deserializer.sv
module tb_byte_deserializer;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  byte_deserializer_if #(.BYTE_W(8), .OUT_W(32)) bus ();

  byte_deserializer #(.BYTE_W(8), .OUT_W(32)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  // {out, out_valid, busy, mode_err}
  function automatic logic [34:0] obs();
    return {bus.out, bus.out_valid, bus.busy, bus.mode_err};
  endfunction

  // Present one cycle of input, then sample 1 time unit after the edge.
  task automatic step(input logic [1:0] m, input logic v, input logic [7:0] b,
                      input logic a);
    bus.mode = m; bus.in_valid = v; bus.in = b; bus.align = a;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.mode = 2'b00; bus.in_valid = 1'b0; bus.in = 8'h00; bus.align = 1'b0;
    reset_L = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (obs() !== {32'h0, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset: got %h want %h", obs(), {32'h0, 3'b000});
    else pass_cnt++;
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  task automatic test_mode8();
    logic [7:0] b [3] = '{8'hA1, 8'hB2, 8'hC3};
    for (int i = 0; i < 3; i++) begin
      step(2'b00, 1'b1, b[i], 1'b0);
      total_cnt++;
      if (obs() !== {24'h0, b[i], 1'b1, 1'b0, 1'b0})
        $display("FAIL mode8_%0d: got %h want %h", i, obs(), {24'h0, b[i], 3'b100});
      else pass_cnt++;
    end
  endtask

  task automatic test_mode16();
    logic [7:0]  b [4] = '{8'h34, 8'h12, 8'h78, 8'h56};
    logic [34:0] e [4] = '{{32'h000000C3, 3'b010}, {32'h00001234, 3'b100},
                           {32'h00001234, 3'b010}, {32'h00005678, 3'b100}};
    for (int i = 0; i < 4; i++) begin
      step(2'b01, 1'b1, b[i], 1'b0);
      total_cnt++;
      if (obs() !== e[i])
        $display("FAIL mode16_%0d: got %h want %h", i, obs(), e[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_gaps32();
    logic [7:0] b [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    for (int i = 0; i < 4; i++) begin
      step(2'b10, 1'b1, b[i], 1'b0);
      total_cnt++;
      if (i < 3) begin
        if (obs() !== {32'h00005678, 3'b010})
          $display("FAIL gap32_b%0d: got %h want %h", i, obs(), {32'h00005678, 3'b010});
        else pass_cnt++;
        for (int g = 0; g < 2; g++) begin
          step(2'b10, 1'b0, 8'hFF, 1'b0);
          total_cnt++;
          if (obs() !== {32'h00005678, 3'b010})
            $display("FAIL gap32_idle%0d_%0d: got %h want %h", i, g, obs(),
                     {32'h00005678, 3'b010});
          else pass_cnt++;
        end
      end else begin
        if (obs() !== {32'hDEADBEEF, 3'b100})
          $display("FAIL gap32_word: got %h want %h", obs(), {32'hDEADBEEF, 3'b100});
        else pass_cnt++;
      end
    end
    step(2'b10, 1'b0, 8'h00, 1'b0);
    total_cnt++;
    if (obs() !== {32'hDEADBEEF, 3'b000})
      $display("FAIL gap32_hold: got %h want %h", obs(), {32'hDEADBEEF, 3'b000});
    else pass_cnt++;
  endtask

  task automatic test_mode_switch();
    step(2'b10, 1'b1, 8'h11, 1'b0);
    step(2'b10, 1'b1, 8'h22, 1'b0);
    total_cnt++;
    if (obs() !== {32'hDEADBEEF, 3'b010})
      $display("FAIL switch_partial: got %h want %h", obs(), {32'hDEADBEEF, 3'b010});
    else pass_cnt++;
    step(2'b00, 1'b1, 8'h55, 1'b0);
    total_cnt++;
    if (obs() !== {32'h00000055, 3'b101})
      $display("FAIL switch_err: got %h want %h", obs(), {32'h00000055, 3'b101});
    else pass_cnt++;
    step(2'b00, 1'b0, 8'h00, 1'b0);
    total_cnt++;
    if (obs() !== {32'h00000055, 3'b000})
      $display("FAIL switch_after: got %h want %h", obs(), {32'h00000055, 3'b000});
    else pass_cnt++;
  endtask

  task automatic test_align_rsvd();
    logic [7:0] b [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    step(2'b10, 1'b1, 8'hAA, 1'b0);
    step(2'b10, 1'b1, 8'hBB, 1'b0);
    step(2'b10, 1'b1, 8'hCC, 1'b0);
    step(2'b10, 1'b1, 8'h99, 1'b1);
    total_cnt++;
    if (obs() !== {32'h00000055, 3'b000})
      $display("FAIL align_drop: got %h want %h", obs(), {32'h00000055, 3'b000});
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      step(2'b10, 1'b1, b[i], 1'b0);
      total_cnt++;
      if (i < 3) begin
        if (obs() !== {32'h00000055, 3'b010})
          $display("FAIL align_b%0d: got %h want %h", i, obs(), {32'h00000055, 3'b010});
        else pass_cnt++;
      end else begin
        if (obs() !== {32'h04030201, 3'b100})
          $display("FAIL align_word: got %h want %h", obs(), {32'h04030201, 3'b100});
        else pass_cnt++;
      end
    end
    step(2'b11, 1'b1, 8'hFF, 1'b0);
    total_cnt++;
    if (obs() !== {32'h04030201, 3'b001})
      $display("FAIL rsvd: got %h want %h", obs(), {32'h04030201, 3'b001});
    else pass_cnt++;
    // Reserved byte mid-word also abandons the partial word.
    step(2'b01, 1'b1, 8'h77, 1'b0);
    step(2'b11, 1'b1, 8'hEE, 1'b0);
    total_cnt++;
    if (obs() !== {32'h04030201, 3'b001})
      $display("FAIL rsvd_mid: got %h want %h", obs(), {32'h04030201, 3'b001});
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    logic [7:0] b [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
    step(2'b10, 1'b1, 8'h01, 1'b0);
    step(2'b10, 1'b1, 8'h02, 1'b0);
    total_cnt++;
    if (obs() !== {32'h04030201, 3'b010})
      $display("FAIL areset_pre: got %h want %h", obs(), {32'h04030201, 3'b010});
    else pass_cnt++;
    bus.in_valid = 1'b0;
    #3 reset_L = 1'b0;
    #1;
    total_cnt++;
    if (obs() !== {32'h0, 3'b000})
      $display("FAIL areset_now: got %h want %h", obs(), {32'h0, 3'b000});
    else pass_cnt++;
    @(negedge clk);
    reset_L = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(2'b10, 1'b1, b[i], 1'b0);
      total_cnt++;
      if (i < 3) begin
        if (obs() !== {32'h0, 3'b010})
          $display("FAIL areset_b%0d: got %h want %h", i, obs(), {32'h0, 3'b010});
        else pass_cnt++;
      end else begin
        if (obs() !== {32'h40302010, 3'b100})
          $display("FAIL areset_word: got %h want %h", obs(), {32'h40302010, 3'b100});
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode8();
    test_mode16();
    test_gaps32();
    test_mode_switch();
    test_align_rsvd();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
